instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Reverse of the pipeline's instruction classifier. Accepts decoded instruction requests (mnemonic select plus fields) over a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word and writes it sequentially into the instruction-memory load port, starting at BASE_ADDR.
- Sits between the testbench/boot loader and IM. It is used to build programs in-system for the P5 pipeline.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of the first word written.
- DEPTH, 1024, maximum number of words written before the block reports full.
- CW, 11, width of the word counter; must satisfy 2**CW > DEPTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- op_sel  input  4  0=addu 1=subu 2=ori 3=lui 4=lw 5=sw 6=beq 7=jal 8=jr; 9..15 illegal.
- rs  input  5  source register.
- rt  input  5  target register.
- rd  input  5  destination register (R-type only).
- imm  input  16  immediate or offset.
- target  input  26  jal word target.
- restart  input  1  one-cycle pulse; rewind to BASE_ADDR and clear status.
- im_we  output  1  IM write strobe, one cycle per word.
- im_addr  output  32  byte address of the write.
- im_wdata  output  32  encoded instruction.
- count  output  CW  words written since reset or restart.
- full  output  1  count==DEPTH.
- illegal  output  1  sticky; an illegal op_sel was consumed.

Behaviour:
- Reset (synchronous, active-high) sets state=RUN, im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, full=0, illegal=0. Reset overrides every other input, including mid-stream.
- States:
  - RUN: in_ready=1.
  - FULL: in_ready=0, full=1.
- Transfers:
  - A transfer occurs at a rising edge with in_valid&&in_ready.
  - Legal op: im_we=1 with im_wdata set to the encoding in the next cycle. im_addr holds the address of that word. Latency is exactly 1 cycle.
  - Consecutive transfers are allowed every cycle, so back-to-back writes are supported.
- Addressing:
  - The first write uses BASE_ADDR. im_addr advances by +4 on the edge following each write.
  - count increments in the same cycle that im_we is asserted.
- Encoding (all fields not listed are zero):
  - addu: {000000,rs,rt,rd,00000,100001}
  - subu: {000000,rs,rt,rd,00000,100011}
  - ori: {001101,rs,rt,imm}
  - lui: {001111,00000,rt,imm}
  - lw: {100011,rs,rt,imm}
  - sw: {101011,rs,rt,imm}
  - beq: {000100,rs,rt,imm}
  - jal: {000011,target}
  - jr: {000000,rs,15'b0,001000}
- Illegal op_sel:
  - The request is consumed, since in_ready was high.
  - No write occurs: im_we=0, address and count unchanged. illegal is set to 1 and stays set until reset or restart.
- Full handling:
  - When a write brings count to DEPTH, the state moves to FULL on that same edge. in_ready=0 from the next cycle.
  - In FULL, requests are stalled, not dropped.
- restart:
  - Next cycle: im_addr=BASE_ADDR, count=0, full=0, illegal=0, state=RUN, im_we=0.
  - A request presented in the same cycle as restart is not accepted; in_ready is forced low during restart.
- in_ready is combinational from state and restart only; it never depends on in_valid.
- im_we is deasserted in every cycle without a legal transfer on the previous edge.

Test Plan:
- Reset, then addu rs=1 rt=2 rd=3 -> next cycle im_we=1, im_addr=0x3000, im_wdata=0x00221821, count=1.
- Back-to-back ori rs=0 rt=1 imm=0x1234, lui rt=2 imm=0xFFFF (lui rs field driven to 5'h1F), jal target=0x0000C03:
  - Expect im_wdata 0x34011234 @0x3000, 0x3C02FFFF @0x3004, 0x0C000C03 @0x3008 on three consecutive cycles.
- lw rs=0 rt=4 imm=0x0010, sw rs=0 rt=4 imm=0x0014, beq rs=1 rt=2 imm=0xFFFE, jr rs=31:
  - Expect 0x8C040010, 0xAC040014, 0x1022FFFE, 0x03E00008.
- op_sel=12 between two legal ops:
  - Expect no write for it, illegal=1, and the second legal op written at +4 from the first.
- DEPTH=4 override, write 4 words with in_valid held high for a 5th:
  - Expect full=1 and in_ready=0 after the 4th, no 5th write.
  - Pulse restart, then expect the 5th request written at 0x3000 with count=1.
- Assert reset while streaming at count=3:
  - Next cycle expect im_we=0, count=0, im_addr=0x3000, illegal=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes decoded instruction requests into MIPS words and streams them into the IM load port.
// Latency: one cycle from an accepted request to im_we/im_wdata.
// Backpressure: in_ready drops while full or during restart; stalled requests are held, not dropped.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024,
  parameter int          CW        = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  input  logic          restart,
  output logic          im_we,
  output logic [31:0]   im_addr,
  output logic [31:0]   im_wdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          illegal
);

  typedef enum logic {RUN, FULL} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        xfer;
  logic        legal;
  logic [31:0] enc;
  logic        last_word;

  // Combinational encoder; legal is low for the unused op_sel codes.
  always_comb begin
    legal = 1'b1;
    enc   = 32'h0;
    case (op_sel)
      4'd0:    enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      4'd1:    enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd2:    enc = {6'b001101, rs, rt, imm};
      4'd3:    enc = {6'b001111, 5'b00000, rt, imm};
      4'd4:    enc = {6'b100011, rs, rt, imm};
      4'd5:    enc = {6'b101011, rs, rt, imm};
      4'd6:    enc = {6'b000100, rs, rt, imm};
      4'd7:    enc = {6'b000011, target};
      4'd8:    enc = {6'b000000, rs, 15'b0, 6'b001000};
      default: legal = 1'b0;
    endcase
  end

  // Handshake and next-state logic; in_ready depends only on state and restart.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == RUN) && !restart;
    xfer      = in_valid && in_ready;
    last_word = (count + 1'b1) == CW'(DEPTH);
    if (restart) begin
      state_d = RUN;
    end else if (xfer && legal && last_word) begin
      state_d = FULL;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Write port, word counter and sticky illegal flag. im_addr sits on the
  // word being written while im_we is high and steps past it on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_we    <= 1'b0;
      im_addr  <= BASE_ADDR;
      im_wdata <= 32'h0;
      count    <= '0;
      illegal  <= 1'b0;
    end else if (restart) begin
      im_we    <= 1'b0;
      im_addr  <= BASE_ADDR;
      count    <= '0;
      illegal  <= 1'b0;
    end else begin
      im_we   <= xfer && legal;
      im_addr <= im_we ? im_addr + 32'd4 : im_addr;
      if (xfer && legal) begin
        im_wdata <= enc;
        count    <= count + 1'b1;
      end
      if (xfer && !legal) begin
        illegal <= 1'b1;
      end
    end
  end

  assign full = (state_q == FULL);

endmodule
